// File: rtl/spi_flash_host.sv
// SPI mode-0 command master for a serial NOR flash.
// Shifts opcode / 24-bit address MSB-first and streams read bytes back as pulses.
module spi_flash_host #(
    parameter int CLK_DIV = 4,
    parameter int CS_IDLE = 2
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_opcode,
    input  logic [23:0] cmd_addr,
    input  logic [7:0]  cmd_len,
    output logic        rd_valid,
    output logic [7:0]  rd_data,
    output logic        rd_last,
    output logic        done,
    output logic        busy,
    output logic        spi_clk,
    output logic        cs_n,
    output logic        mosi,
    input  logic        miso
);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t      state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic [7:0]  gap_q, gap_d;
    logic [11:0] bit_q, bit_d;
    logic [11:0] total_q, total_d;
    logic [31:0] sh_q, sh_d;
    logic [7:0]  rx_q, rx_d;
    logic [7:0]  len_q, len_d;
    logic        is_rd_q, is_rd_d;
    logic        sclk_q, sclk_d;
    logic        cs_q, cs_d;
    logic        mosi_q, mosi_d;
    logic        rdv_q, rdv_d;
    logic        rdl_q, rdl_d;
    logic [7:0]  rdd_q, rdd_d;

    logic [11:0] dbit;
    logic        data_phase;
    logic [7:0]  rx_next;

    // Bit index relative to the first data-phase bit (valid only when data_phase).
    assign dbit       = bit_q - 12'd32;
    assign data_phase = is_rd_q && (bit_q >= 12'd32);
    assign rx_next    = {rx_q[6:0], miso};

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        gap_d   = gap_q;
        bit_d   = bit_q;
        total_d = total_q;
        sh_d    = sh_q;
        rx_d    = rx_q;
        len_d   = len_q;
        is_rd_d = is_rd_q;
        sclk_d  = sclk_q;
        cs_d    = cs_q;
        mosi_d  = mosi_q;
        rdv_d   = 1'b0;
        rdl_d   = 1'b0;
        rdd_d   = rdd_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d = SHIFT;
                    cs_d    = 1'b0;
                    sclk_d  = 1'b0;
                    div_d   = '0;
                    bit_d   = '0;
                    sh_d    = {cmd_opcode, cmd_addr};
                    mosi_d  = cmd_opcode[7];
                    len_d   = cmd_len;
                    is_rd_d = (cmd_opcode == 8'h03);
                    if (cmd_opcode == 8'h03)
                        total_d = 12'd40 + {1'b0, cmd_len, 3'b000};
                    else if (cmd_opcode == 8'h20)
                        total_d = 12'd32;
                    else
                        total_d = 12'd8;
                end
            end
            SHIFT: begin
                if (div_q == 8'(CLK_DIV - 1)) begin
                    div_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                        if (data_phase) begin
                            rx_d = rx_next;
                            if (dbit[2:0] == 3'd7) begin
                                rdv_d = 1'b1;
                                rdd_d = rx_next;
                                rdl_d = (dbit[11:3] == {1'b0, len_q});
                            end
                        end
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q == total_q - 12'd1) begin
                            state_d = GAP;
                            cs_d    = 1'b1;
                            mosi_d  = 1'b0;
                            gap_d   = '0;
                        end else begin
                            // Zeros shift in behind the address, so the data phase drives mosi=0.
                            bit_d  = bit_q + 12'd1;
                            sh_d   = {sh_q[30:0], 1'b0};
                            mosi_d = sh_q[30];
                        end
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            GAP: begin
                if (gap_q == 8'(CS_IDLE - 1))
                    state_d = IDLE;
                else
                    gap_d = gap_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            gap_q   <= '0;
            bit_q   <= '0;
            total_q <= '0;
            sh_q    <= '0;
            rx_q    <= '0;
            len_q   <= '0;
            is_rd_q <= 1'b0;
            sclk_q  <= 1'b0;
            cs_q    <= 1'b1;
            mosi_q  <= 1'b0;
            rdv_q   <= 1'b0;
            rdl_q   <= 1'b0;
            rdd_q   <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            gap_q   <= gap_d;
            bit_q   <= bit_d;
            total_q <= total_d;
            sh_q    <= sh_d;
            rx_q    <= rx_d;
            len_q   <= len_d;
            is_rd_q <= is_rd_d;
            sclk_q  <= sclk_d;
            cs_q    <= cs_d;
            mosi_q  <= mosi_d;
            rdv_q   <= rdv_d;
            rdl_q   <= rdl_d;
            rdd_q   <= rdd_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == GAP) && (gap_q == 8'(CS_IDLE - 1));
    assign rd_valid  = rdv_q;
    assign rd_last   = rdl_q;
    assign rd_data   = rdd_q;
    assign spi_clk   = sclk_q;
    assign cs_n      = cs_q;
    assign mosi      = mosi_q;

endmodule
